// File: rtl/multicycle_control_pkg.sv
// Shared definitions for the multicycle controller and its datapath:
// state encoding, opcode constants, ALU operand-B selects, ALU op codes.
package multicycle_control_pkg;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXEC_R   = 4'd6,
        EXEC_I   = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9,
        TRAP     = 4'd10
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_OR  = 3'b110;
    localparam logic [2:0] F3_AND = 3'b111;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;

    // Registered control word. 'branch' marks the state whose PC write is
    // qualified by the live ALU zero flag rather than a stored value.
    typedef struct packed {
        logic       pc_write;
        logic       branch;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [3:0] alu_ctl;
        logic       reg_write;
        logic       pc_source;
        logic       illegal;
    } ctrl_t;

    // Moore output table: control word driven while sitting in state s.
    // exec_alu is only consulted for the execute states.
    function automatic ctrl_t ctrl_for(input state_t s, input logic [3:0] exec_alu);
        ctrl_t c;
        c = '0;
        case (s)
            FETCH: begin
                c.mem_read  = 1'b1;
                c.ir_write  = 1'b1;
                c.alu_src_b = SRCB_FOUR;
                c.alu_ctl   = ALU_ADD;
            end
            DECODE: begin
                c.pc_write  = 1'b1;
                c.pc_source = 1'b1;
                c.alu_src_b = SRCB_IMM;
                c.alu_ctl   = ALU_ADD;
            end
            MEMADR: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_IMM;
                c.alu_ctl   = ALU_ADD;
            end
            MEMREAD: begin
                c.mem_read  = 1'b1;
                c.iord      = 1'b1;
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_IMM;
                c.alu_ctl   = ALU_ADD;
            end
            MEMWB: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
            end
            MEMWRITE: begin
                c.mem_write = 1'b1;
                c.iord      = 1'b1;
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_IMM;
                c.alu_ctl   = ALU_ADD;
            end
            EXEC_R: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_REG;
                c.alu_ctl   = exec_alu;
            end
            EXEC_I: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_IMM;
                c.alu_ctl   = exec_alu;
            end
            ALUWB: begin
                c.reg_write = 1'b1;
            end
            BRANCH: begin
                c.branch    = 1'b1;
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_REG;
                c.alu_ctl   = ALU_SUB;
                c.pc_source = 1'b1;
            end
            TRAP: begin
                c.illegal = 1'b1;
            end
            default: ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Controller <-> datapath bundle. There is no valid/ready handshake here:
// every signal is a level that is meaningful in each clock cycle; the
// controller (master) drives the control word and state, the datapath
// (slave) drives the instruction fields and the ALU zero flag.
interface multicycle_control_if;
    import multicycle_control_pkg::*;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7_5;
    logic       zero;

    logic       PCWrite;
    logic       IorD;
    logic       MemRead;
    logic       MemWrite;
    logic       IRWrite;
    logic       MemtoReg;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [3:0] ALUControl;
    logic       RegWrite;
    logic       PCSource;
    logic       illegal;
    state_t     state;

    modport master (
        input  opcode, funct3, funct7_5, zero,
        output PCWrite, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
               ALUSrcA, ALUSrcB, ALUControl, RegWrite, PCSource,
               illegal, state
    );

    modport slave (
        output opcode, funct3, funct7_5, zero,
        input  PCWrite, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
               ALUSrcA, ALUSrcB, ALUControl, RegWrite, PCSource,
               illegal, state
    );

endinterface

// File: rtl/alu_control.sv
// Combinational funct decode: ALU op for R/I-type execute and whether the
// funct3 value is one this machine implements.
module alu_control
    import multicycle_control_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    input  logic       r_type,
    output logic [3:0] alu_ctl,
    output logic       legal
);

    // funct3 selects the op; funct7_5 only turns ADD into SUB for R-type
    // (for I-type that bit belongs to the immediate).
    always_comb begin
        alu_ctl = ALU_ADD;
        legal   = 1'b1;
        case (funct3)
            F3_ADD:  alu_ctl = (r_type && funct7_5) ? ALU_SUB : ALU_ADD;
            F3_AND:  alu_ctl = ALU_AND;
            F3_OR:   alu_ctl = ALU_OR;
            default: legal   = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle RISC-V style main controller. Moore FSM with registered
// control outputs; enables are forced low while reset is high so a reset
// landing mid-instruction aborts it without any further writes.
module multicycle_control
    import multicycle_control_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    multicycle_control_if.master  bus
);

    state_t     state_q;
    state_t     state_next;
    ctrl_t      ctrl_q;
    logic [3:0] exec_alu;
    logic       funct_legal;

    alu_control u_alu_control (
        .funct3   (bus.funct3),
        .funct7_5 (bus.funct7_5),
        .r_type   (bus.opcode == OP_RTYPE),
        .alu_ctl  (exec_alu),
        .legal    (funct_legal)
    );

    // Next-state selection; DECODE dispatches on opcode and funct legality.
    always_comb begin
        state_next = state_q;
        case (state_q)
            FETCH:  state_next = DECODE;
            DECODE: begin
                case (bus.opcode)
                    OP_LOAD, OP_STORE: state_next = MEMADR;
                    OP_RTYPE:          state_next = funct_legal ? EXEC_R : TRAP;
                    OP_ITYPE:          state_next = funct_legal ? EXEC_I : TRAP;
                    OP_BRANCH:         state_next = BRANCH;
                    default:           state_next = TRAP;
                endcase
            end
            MEMADR:   state_next = (bus.opcode == OP_LOAD) ? MEMREAD : MEMWRITE;
            MEMREAD:  state_next = MEMWB;
            MEMWB:    state_next = FETCH;
            MEMWRITE: state_next = FETCH;
            EXEC_R:   state_next = ALUWB;
            EXEC_I:   state_next = ALUWB;
            ALUWB:    state_next = FETCH;
            BRANCH:   state_next = FETCH;
            TRAP:     state_next = TRAP;
            default:  state_next = FETCH;
        endcase
    end

    // State register plus the control word for the state being entered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FETCH;
            ctrl_q  <= ctrl_for(FETCH, ALU_ADD);
        end else begin
            state_q <= state_next;
            ctrl_q  <= ctrl_for(state_next, exec_alu);
        end
    end

    // The branch PC write depends on the zero flag the ALU produces during
    // BRANCH itself, so it is qualified combinationally.
    assign bus.PCWrite    = ~reset & (ctrl_q.pc_write | (ctrl_q.branch & bus.zero));
    assign bus.MemRead    = ~reset & ctrl_q.mem_read;
    assign bus.MemWrite   = ~reset & ctrl_q.mem_write;
    assign bus.IRWrite    = ~reset & ctrl_q.ir_write;
    assign bus.RegWrite   = ~reset & ctrl_q.reg_write;
    assign bus.IorD       = ctrl_q.iord;
    assign bus.MemtoReg   = ctrl_q.mem_to_reg;
    assign bus.ALUSrcA    = ctrl_q.alu_src_a;
    assign bus.ALUSrcB    = ctrl_q.alu_src_b;
    assign bus.ALUControl = ctrl_q.alu_ctl;
    assign bus.PCSource   = ctrl_q.pc_source;
    assign bus.illegal    = ctrl_q.illegal;
    assign bus.state      = state_q;

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 The block SHALL have one clock, clk; reset is synchronous and active-high, named reset.
REQ-002 Ports SHALL be:
- clk in 1: rising-edge clock
- reset in 1: synchronous, active-high
- opcode in 7: inst[6:0] from IR
- funct3 in 3: inst[14:12]
- funct7_5 in 1: inst[30]
- zero in 1: ALU zero flag
- PCWrite out 1: PC load enable (already gated by zero for branches)
- IorD out 1: 1 = memory address is ALUOut
- MemRead out 1: memory read enable
- MemWrite out 1: memory write enable
- IRWrite out 1: IR load enable
- MemtoReg out 1: 1 = writeback from MDR
- ALUSrcA out 1: 1 = A, 0 = PC
- ALUSrcB out 2: 00 = B, 01 = 4, 10 = imm
- ALUControl out 4: AND 0000, OR 0001, ADD 0010, SUB 0110
- RegWrite out 1: register file write enable
- PCSource out 1: 1 = ALUOut, 0 = ALUResult
- illegal out 1: high while in TRAP
- state out 4: current state, for debug

Function
REQ-003 The block SHALL be a Moore FSM with states FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXEC_R, EXEC_I, ALUWB, BRANCH, TRAP; every unlisted output is 0 in each state.
REQ-004 FETCH SHALL assert MemRead=1, IorD=0, IRWrite=1, ALUSrcA=0, ALUSrcB=01, ADD, PCWrite=0, and go to DECODE.
REQ-005 DECODE SHALL assert PCWrite=1, PCSource=1 (so PC <= PC+4 from ALUOut), ALUSrcA=0, ALUSrcB=10, ADD (so ALUOut <= old PC + imm).
REQ-006 DECODE SHALL branch on opcode: 0000011 or 0100011 to MEMADR; 0110011 to EXEC_R; 0010011 to EXEC_I; 1100011 to BRANCH; any other opcode, or an unsupported funct (REQ-012), to TRAP.
REQ-007 MEMADR SHALL assert ALUSrcA=1, ALUSrcB=10, ADD, then go to MEMREAD if opcode=0000011, otherwise to MEMWRITE.
REQ-008 MEMREAD SHALL assert MemRead=1, IorD=1, and hold ALUSrcA=1, ALUSrcB=10, ADD so ALUOut stays stable, then go to MEMWB; MEMWB SHALL assert RegWrite=1, MemtoReg=1, then go to FETCH.
REQ-009 MEMWRITE SHALL assert MemWrite=1, IorD=1, ALUSrcA=1, ALUSrcB=10, ADD, then go to FETCH.
REQ-010 EXEC_R SHALL assert ALUSrcA=1, ALUSrcB=00; EXEC_I SHALL assert ALUSrcA=1, ALUSrcB=10; both SHALL go to ALUWB, which asserts RegWrite=1, MemtoReg=0, then goes to FETCH.
REQ-011 BRANCH SHALL assert ALUSrcA=1, ALUSrcB=00, SUB, PCSource=1, PCWrite=zero, then go to FETCH.
REQ-012 ALUControl in EXEC_R / EXEC_I SHALL decode as:
- funct3=000: ADD, or SUB when R-type and funct7_5=1
- funct3=111: AND
- funct3=110: OR
- any other funct3: illegal, detected in DECODE
REQ-013 TRAP SHALL hold illegal=1 with all enables 0 and SHALL remain in TRAP until reset.
REQ-014 Instruction latency SHALL be: lw 5 cycles; sw, R-type, I-type 4 cycles; beq 3 cycles.

Reset
REQ-015 While reset=1 at a clock edge, the state SHALL become FETCH.
REQ-016 While reset=1, all enable outputs (PCWrite, MemRead, MemWrite, IRWrite, RegWrite) SHALL be 0.
REQ-017 Reset asserted in any state, including TRAP or mid-instruction, SHALL abort the instruction with no further writes; the first cycle after reset deasserts SHALL be FETCH.

Structure
REQ-018 A shared package SHALL hold the state encoding, opcode constants, ALUSrcB select codes and ALUControl codes, for use by this block and the datapath.
REQ-019 The ALUControl/funct decode SHALL be a combinational sub-module, alu_control, that also reports funct legality.

Verification
REQ-020 addi (0x01400193): 4 cycles FETCH, DECODE, EXEC_I, ALUWB; PCWrite=1 only in DECODE; RegWrite=1 only in cycle 4; ALUControl=0010.
REQ-021 lw (0x0781A403): 5 cycles; IorD=1 and MemRead=1 in MEMREAD; RegWrite=1 and MemtoReg=1 in MEMWB.
REQ-022 add (0x00340533) -> ALUControl=0010 in EXEC_R; same funct with funct7_5=1 -> 0110; sw (opcode 0100011) -> MemWrite=1 for exactly 1 cycle.
REQ-023 beq with zero=1 in BRANCH -> PCWrite=1, PCSource=1; with zero=0 -> PCWrite=0; both return to FETCH after 3 cycles.
REQ-024 opcode 0000000 -> TRAP, illegal=1 for 10+ cycles, no enables asserted; reset asserted in MEMREAD -> FETCH next cycle, RegWrite never asserts.
